// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// plus load-use hazard detection that requests a one-cycle ID stall.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_alusrc_i,
  input  logic [CTRL_W-1:0] id_aluctrl_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              exm_regwrite_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              mwb_regwrite_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic [DATA_W-1:0] mwb_data_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [CTRL_W-1:0] aluctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o
);

  logic              valid_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, alusrc_q;
  logic [REG_AW-1:0] rd_q, rs_addr_q, rt_addr_q;
  logic [CTRL_W-1:0] aluctrl_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic              bubble;
  logic              rs_hit, rt_hit;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // A store reads rt for its data even when operand B is the immediate.
  assign rs_hit  = (id_rs_addr_i == rd_q);
  assign rt_hit  = (id_rt_addr_i == rd_q) && (!id_alusrc_i || id_memwrite_i);
  assign stall_o = valid_q && memread_q && (rd_q != '0) && id_valid_i &&
                   (rs_hit || rt_hit) && !hold_i && !flush_i;
  assign bubble  = flush_i || stall_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      rd_q       <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      aluctrl_q  <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else if (!hold_i) begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      alusrc_q  <= id_alusrc_i;
      rs_addr_q <= id_rs_addr_i;
      rt_addr_q <= id_rt_addr_i;
      rs_data_q <= id_rs_data_i;
      rt_data_q <= id_rt_data_i;
      imm_q     <= id_imm_i;
      if (bubble) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        rd_q       <= '0;
        aluctrl_q  <= '0;
      end else begin
        valid_q    <= id_valid_i;
        regwrite_q <= id_regwrite_i;
        memread_q  <= id_memread_i;
        memwrite_q <= id_memwrite_i;
        memtoreg_q <= id_memtoreg_i;
        rd_q       <= id_rd_addr_i;
        aluctrl_q  <= id_aluctrl_i;
      end
    end
  end

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] reg_data,
    input logic              exm_we,
    input logic [REG_AW-1:0] exm_rd,
    input logic [DATA_W-1:0] exm_data,
    input logic              mwb_we,
    input logic [REG_AW-1:0] mwb_rd,
    input logic [DATA_W-1:0] mwb_data
  );
    if (exm_we && (exm_rd != '0) && (exm_rd == addr))
      return exm_data;
    else if (mwb_we && (mwb_rd != '0) && (mwb_rd == addr))
      return mwb_data;
    else
      return reg_data;
  endfunction

  assign rs_fwd = fwd_sel(rs_addr_q, rs_data_q, exm_regwrite_i, exm_rd_i, exm_data_i,
                          mwb_regwrite_i, mwb_rd_i, mwb_data_i);
  assign rt_fwd = fwd_sel(rt_addr_q, rt_data_q, exm_regwrite_i, exm_rd_i, exm_data_i,
                          mwb_regwrite_i, mwb_rd_i, mwb_data_i);

  assign data0_o       = rs_fwd;
  assign data1_o       = alusrc_q ? imm_q : rt_fwd;
  assign store_data_o  = rt_fwd;
  assign aluctrl_o     = aluctrl_q;
  assign ex_valid_o    = valid_q;
  assign ex_rd_o       = rd_q;
  assign ex_regwrite_o = regwrite_q & valid_q;
  assign ex_memread_o  = memread_q  & valid_q;
  assign ex_memwrite_o = memwrite_q & valid_q;
  assign ex_memtoreg_o = memtoreg_q & valid_q;

endmodule
